edge_shift_bank: RTL and testbench
==================================

# edge_shift_bank

- Parametrised register bank: a DEPTH-stage, WIDTH-bit shift pipeline with clock enable, synchronous reset, optional recirculation, and a fill counter.
- A falling-edge output register re-times the last stage so downstream logic can sample it half a cycle later.
- Generalises the fixed small flop/vector test structures into one reusable block for flop-inference and mixed-edge regression designs.

## Interface

- WIDTH, 5, data width of every stage.
- DEPTH, 4, number of rising-edge stages (at least 1).
- RST_POS, all zeros, reset value of every rising-edge stage.
- RST_NEG, all ones, reset value of the falling-edge output register.
- clk  in  1  single clock; all state is updated on rising or falling edges of clk.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable, active-high.
- rot  in  1  1 = recirculate the last stage into stage 0; 0 = shift din into stage 0.
- din  in  WIDTH  serial data input.
- q_pos  out  WIDTH  last rising-edge stage.
- q_neg  out  WIDTH  falling-edge capture of q_pos.
- fill  out  $clog2(DEPTH+1)  count of enabled shifts since reset, saturating at DEPTH.
- valid  out  1  fill == DEPTH.

## Operation

**Rising edge of clk:**
- rst=1: all stages <= RST_POS; fill <= 0. rst overrides cen and rot.
- rst=0, cen=1: stage[i] <= stage[i-1] for i ≥ 1.
  - stage[0] <= stage[DEPTH-1] when rot=1, else din.
  - fill <= fill+1, saturating at DEPTH.
- rst=0, cen=0: all stages and fill hold. din and rot are ignored.

**Falling edge of clk:**
- rst=1: q_neg <= RST_NEG.
- rst=0, cen=1: q_neg <= q_pos.
- rst=0, cen=0: q_neg holds.

**Outputs:**
- q_pos = stage[DEPTH-1]; valid = (fill == DEPTH). Both are combinational from registers and have no input-to-output path.
- Reset values: q_pos = RST_POS, q_neg = RST_NEG, fill = 0, valid = 0.

**Other rules:**
- rot=1 with fill < DEPTH recirculates whatever the stages hold, reset values included. fill still counts.
- DEPTH=1: with rot=1 the stage holds its value on every enabled edge.

## Timing

- rst, cen, rot and din are sampled on the rising edge for the shift pipeline.
- rst and cen are also sampled on the falling edge for q_neg. A pulse visible at only one edge affects only that edge's registers.
- Latency din -> q_pos: DEPTH enabled rising edges.
- Latency q_pos -> q_neg: the next falling edge with cen=1.
- Reset mid-operation:
  - The rising edge that sees rst clears the pipeline and fill in the same cycle.
  - valid drops immediately after that edge.
  - q_neg shows RST_NEG from the next falling edge that sees rst, until the first falling edge with rst=0 and cen=1.
- fill saturates at DEPTH: further enabled shifts keep it at DEPTH, with no wrap-around.
- cen low between enabled edges stalls the pipeline without changing fill or valid.

## Structure

- Shared package edge_shift_pkg holds:
  - the default constants for WIDTH, DEPTH, RST_POS and RST_NEG;
  - a function computing the fill width.
- One sub-module, edge_shift_stage: a single WIDTH-bit rising-edge register with sync reset value and enable.
  - Instantiated DEPTH times through a generate loop.
- The falling-edge register and the fill counter stay in the top module.

## Test plan

All scenarios use WIDTH=5, DEPTH=4.

1. **Reset:** rst=1 across one rising and one falling edge -> q_pos=00000, q_neg=11111, fill=0, valid=0.
2. **Fill:** rst=0, cen=1, rot=0, din=00001 held.
   - After 3 rising edges: fill=3, valid=0, q_pos=00000.
   - After the 4th rising edge: q_pos=00001, fill=4, valid=1.
   - Next falling edge: q_neg=00001.
3. **Stall:** cen=0 for 3 full cycles with din=10101 -> q_pos, q_neg and fill unchanged; valid stays 1.
4. **Recirculate:** load din=1,2,3,4 with cen=1, then rot=1, cen=1 for 8 cycles.
   - q_pos sequence 1,2,3,4,1,2,3,4.
   - fill holds at 4.
5. **Half-cycle reset:** rst high only around a falling edge, with pipeline full -> q_neg=11111; q_pos and fill unchanged.
   - The next enabled falling edge restores q_neg=q_pos.
6. **Reset priority:** rst=1 and cen=1 together mid-fill (fill=2) -> fill=0, q_pos=00000; next falling edge q_neg=11111.

Source files
------------

// File: rtl/edge_shift_pkg.sv
// Purpose : shared defaults and helpers for the edge_shift_bank register bank.
// Latency : n/a (package only).
// Backpressure: n/a; the bank stalls on its clock enable and has no handshake.
package edge_shift_pkg;

   localparam int   DEF_WIDTH       = 5;
   localparam int   DEF_DEPTH       = 4;
   // Reset values are expressed per bit so they can be replicated to any WIDTH.
   localparam logic DEF_RST_POS_BIT = 1'b0;
   localparam logic DEF_RST_NEG_BIT = 1'b1;

   // Bits needed to count 0..depth inclusive.
   function automatic int fill_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/edge_shift_stage.sv
// Purpose : one WIDTH-bit rising-edge register with synchronous reset value and enable.
// Latency : d appears on q one enabled rising edge later.
// Backpressure: en low holds q; reset overrides enable.
// Ports   : clk, rst (sync, active-high), en, d -> q.
module edge_shift_stage #(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/edge_shift_bank.sv
// Purpose : DEPTH-stage WIDTH-bit shift pipeline with optional recirculation, fill
//           counter and a falling-edge re-timed copy of the last stage.
// Latency : din -> q_pos after DEPTH enabled rising edges; q_pos -> q_neg on the
//           next falling edge with cen=1.
// Backpressure: cen low stalls every register (stages, fill, q_neg); no handshake.
// Ports   : clk, rst (sync, active-high), cen, rot, din -> q_pos, q_neg, fill, valid.
module edge_shift_bank
   import edge_shift_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter int               DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_POS = {WIDTH{DEF_RST_POS_BIT}},
   parameter logic [WIDTH-1:0] RST_NEG = {WIDTH{DEF_RST_NEG_BIT}}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cen,
   input  logic                            rot,
   input  logic [WIDTH-1:0]                din,
   output logic [WIDTH-1:0]                q_pos,
   output logic [WIDTH-1:0]                q_neg,
   output logic [fill_width(DEPTH)-1:0]    fill,
   output logic                            valid
);

   localparam int            FW       = fill_width(DEPTH);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage0_d;
   logic [FW-1:0]    fill_q;
   logic [WIDTH-1:0] neg_q;

   // With DEPTH=1 recirculation feeds the single stage its own value, so it holds.
   assign stage0_d = rot ? stage_q[DEPTH-1] : din;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_first
         edge_shift_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_POS)
         ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (cen),
            .d   (stage0_d),
            .q   (stage_q[i])
         );
      end else begin : g_rest
         edge_shift_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_POS)
         ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (cen),
            .d   (stage_q[i-1]),
            .q   (stage_q[i])
         );
      end
   end

   // Counts enabled shifts since reset; recirculating shifts count too.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
      end else if (cen && (fill_q != FILL_MAX)) begin
         fill_q <= fill_q + FW'(1);
      end
   end

   // Half-cycle re-timing of the last stage; rst/cen are re-sampled on this edge,
   // so a pulse seen only here affects only q_neg.
   always_ff @(negedge clk) begin
      if (rst) begin
         neg_q <= RST_NEG;
      end else if (cen) begin
         neg_q <= stage_q[DEPTH-1];
      end
   end

   assign q_pos = stage_q[DEPTH-1];
   assign q_neg = neg_q;
   assign fill  = fill_q;
   assign valid = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_edge_shift_bank.sv
// Purpose : self-checking bench for edge_shift_bank (WIDTH=5, DEPTH=4): vector table,
//           hand-written multi-cycle corner cases and a randomized run against a model.
// Latency : inputs change just after falling edges (or mid-cycle for one-edge pulses).
// Backpressure: n/a.
module tb_edge_shift_bank;

   localparam int WIDTH = 5;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cen = 1'b0;
   logic             rot = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] q_pos;
   logic [WIDTH-1:0] q_neg;
   logic [2:0]       fill;
   logic             valid;

   int checks = 0;
   int errors = 0;

   edge_shift_bank dut (
      .clk   (clk),
      .rst   (rst),
      .cen   (cen),
      .rot   (rot),
      .din   (din),
      .q_pos (q_pos),
      .q_neg (q_neg),
      .fill  (fill),
      .valid (valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural model: a queue whose front is the newest entry and back is q_pos.
   logic [WIDTH-1:0] m_q[$];
   int               m_fill;
   logic [WIDTH-1:0] m_neg;

   task automatic model_pos();
      logic [WIDTH-1:0] v;
      if (rst) begin
         m_q = {};
         for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
         m_fill = 0;
      end else if (cen) begin
         v = rot ? m_q[DEPTH-1] : din;
         m_q.push_front(v);
         void'(m_q.pop_back());
         m_fill = (m_fill + 1 > DEPTH) ? DEPTH : m_fill + 1;
      end
   endtask

   task automatic model_neg();
      if (rst) m_neg = '1;
      else if (cen) m_neg = m_q[DEPTH-1];
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pos_edge();
      @(posedge clk);
      model_pos();
      #1;
   endtask

   task automatic neg_edge();
      @(negedge clk);
      model_neg();
      #1;
   endtask

   task automatic step();
      pos_edge();
      neg_edge();
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " q_pos"}, int'(q_pos), int'(m_q[DEPTH-1]));
      chk({tag, " fill"},  int'(fill),  m_fill);
      chk({tag, " valid"}, int'(valid), int'(m_fill == DEPTH));
      chk({tag, " q_neg"}, int'(q_neg), int'(m_neg));
   endtask

   typedef struct {
      logic             rst;
      logic             cen;
      logic             rot;
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] eqp;
      logic [WIDTH-1:0] eqn;
      int               efill;
      logic             evalid;
   } vec_t;

   vec_t vt[$];

   initial begin
      for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
      m_fill = 0;
      m_neg  = '1;

      // Each entry is one full cycle (rising then falling edge) with constant inputs.
      // reset
      vt.push_back('{1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h1f, 0, 1'b0});
      // fill with din=1
      vt.push_back('{1'b0, 1'b1, 1'b0, 5'h01, 5'h00, 5'h00, 1, 1'b0});
      vt.push_back('{1'b0, 1'b1, 1'b0, 5'h01, 5'h00, 5'h00, 2, 1'b0});
      vt.push_back('{1'b0, 1'b1, 1'b0, 5'h01, 5'h00, 5'h00, 3, 1'b0});
      vt.push_back('{1'b0, 1'b1, 1'b0, 5'h01, 5'h01, 5'h01, 4, 1'b1});
      // stall with din=10101
      for (int i = 0; i < 3; i++)
         vt.push_back('{1'b0, 1'b0, 1'b0, 5'h15, 5'h01, 5'h01, 4, 1'b1});
      // load 1,2,3,4 (pipeline already holds 1s, so q_pos stays 1)
      for (int i = 1; i <= 4; i++)
         vt.push_back('{1'b0, 1'b1, 1'b0, 5'(i), 5'h01, 5'h01, 4, 1'b1});
      // recirculate 8 cycles: q_pos walks 2,3,4,1,2,3,4,1 after the current 1
      for (int i = 0; i < 8; i++)
         vt.push_back('{1'b0, 1'b1, 1'b1, 5'h1a, 5'((i + 1) % 4 + 1), 5'((i + 1) % 4 + 1), 4, 1'b1});

      for (int i = 0; i < vt.size(); i++) begin
         rst = vt[i].rst; cen = vt[i].cen; rot = vt[i].rot; din = vt[i].din;
         step();
         chk($sformatf("vec%0d q_pos", i), int'(q_pos), int'(vt[i].eqp));
         chk($sformatf("vec%0d q_neg", i), int'(q_neg), int'(vt[i].eqn));
         chk($sformatf("vec%0d fill",  i), int'(fill),  vt[i].efill);
         chk($sformatf("vec%0d valid", i), int'(valid), int'(vt[i].evalid));
      end

      // Half-cycle reset: rst only around a falling edge, pipeline full.
      rst = 1'b0; cen = 1'b0; rot = 1'b1;
      pos_edge();
      rst = 1'b1;
      neg_edge();
      chk("half_rst q_neg", int'(q_neg), 5'h1f);
      chk("half_rst q_pos", int'(q_pos), 5'h01);
      chk("half_rst fill",  int'(fill),  4);
      rst = 1'b0; cen = 1'b0;
      pos_edge();
      chk("half_rst hold q_pos", int'(q_pos), 5'h01);
      chk("half_rst hold fill",  int'(fill),  4);
      cen = 1'b1;                      // enable seen only at the falling edge
      neg_edge();
      chk("half_rst restore q_neg", int'(q_neg), 5'h01);
      chk("half_rst restore q_pos", int'(q_pos), 5'h01);
      cen = 1'b0;

      // Reset priority mid-fill.
      rst = 1'b1; cen = 1'b0; rot = 1'b0;
      step();
      rst = 1'b0; cen = 1'b1; din = 5'h0b;
      step();
      din = 5'h0c;
      step();
      chk("prio pre fill", int'(fill), 2);
      rst = 1'b1; cen = 1'b1; rot = 1'b1; din = 5'h1e;
      pos_edge();
      chk("prio fill",  int'(fill),  0);
      chk("prio q_pos", int'(q_pos), 5'h00);
      chk("prio valid", int'(valid), 0);
      neg_edge();
      chk("prio q_neg", int'(q_neg), 5'h1f);
      chk_model("prio model");

      // Randomized run against the model, with occasional mid-cycle input changes.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 19) == 0);
         cen = ($urandom_range(0, 3) != 0);
         rot = ($urandom_range(0, 2) == 0);
         din = 5'($urandom);
         pos_edge();
         chk($sformatf("rnd%0d q_pos", n), int'(q_pos), int'(m_q[DEPTH-1]));
         chk($sformatf("rnd%0d fill",  n), int'(fill),  m_fill);
         chk($sformatf("rnd%0d valid", n), int'(valid), int'(m_fill == DEPTH));
         if ($urandom_range(0, 3) == 0) begin
            rst = ($urandom_range(0, 7) == 0);
            cen = $urandom_range(0, 1) == 1;
         end
         neg_edge();
         chk($sformatf("rnd%0d q_neg", n), int'(q_neg), int'(m_neg));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
